adsr_vca: RTL

ADSR_VCA -- requirements
Module: adsr_vca

---
 rtl/adsr_vca.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/adsr_vca.sv
// adsr_vca: ADSR envelope generator driving an 8-bit voltage-controlled amplifier.
// The envelope level advances once per TICK_DIV clocks. The output sample is the input
// sample, taken about midpoint 128, scaled by the top byte of the envelope level.
// The release rate arrives on port release_code because 'release' is a reserved word.
// Optional build macro ADSR_ENV_MON_EN adds output env_out. It carries the registered
// envelope byte, aligned with signal_out.
module adsr_vca #(
  parameter int unsigned TICK_DIV = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gate,
  input  logic [7:0] signal_in,
  input  logic [6:0] attack,
  input  logic [6:0] decay,
  input  logic [6:0] sustain,
  input  logic [6:0] release_code,
  output logic [7:0] signal_out
`ifdef ADSR_ENV_MON_EN
  ,
  output logic [7:0] env_out
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ATTACK,
    S_DECAY,
    S_SUSTAIN,
    S_RELEASE
  } state_t;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  // Rate code to per-tick step: (128 - r)^2, so code 0 is fastest and code 127 is slowest.
  function automatic logic [14:0] rate_step(input logic [6:0] r);
    logic [15:0] d;
    logic [15:0] sq;
    d  = 16'd128 - {9'd0, r};
    sq = d * d;
    return sq[14:0];
  endfunction

  // Rising ramp that saturates at full scale. Returns {reached_top, next_level}.
  function automatic logic [16:0] ramp_up(input logic [15:0] lvl, input logic [14:0] st);
    logic [16:0] sum;
    sum = {1'b0, lvl} + {2'b0, st};
    if (sum >= 17'h0FFFF) return {1'b1, 16'hFFFF};
    else                  return {1'b0, sum[15:0]};
  endfunction

  // Falling ramp that lands exactly on a floor level. Returns {reached_floor, next_level}.
  function automatic logic [16:0] ramp_down(input logic [15:0] lvl, input logic [15:0] floor_lvl,
                                            input logic [14:0] st);
    if ({1'b0, lvl} <= ({1'b0, floor_lvl} + {2'b0, st})) return {1'b1, floor_lvl};
    else                                                 return {1'b0, lvl - {1'b0, st}};
  endfunction

  // Centre the sample on zero, scale it by env/256 with a flooring shift, then re-centre on 128.
  function automatic logic [7:0] vca_scale(input logic [7:0] sig, input logic [7:0] env);
    logic signed [8:0]  s;
    logic signed [17:0] p;
    logic signed [9:0]  q;
    s = $signed({1'b0, sig}) - 9'sd128;
    p = s * $signed({1'b0, env});
    q = 10'(p >>> 8);
    return 8'(q + 10'sd128);
  endfunction

  state_t        state_q, state_d;
  logic [15:0]   lvl_q, lvl_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          gate_prev_q;
  logic          tick;
  logic          gate_rise;
  logic [15:0]   sus_t;
  logic [16:0]   ramp;
  logic [7:0]    env_p0;
  logic [7:0]    out_p0;
  logic [7:0]    out_p1;
  logic [7:0]    env_p1;

  assign tick      = (cnt_q == TICK_LAST);
  assign gate_rise = gate & ~gate_prev_q;
  assign sus_t     = {sustain, 9'b0};
  assign env_p0    = lvl_q[15:8];
  assign out_p0    = vca_scale(signal_in, env_p0);

  // Stage p0: envelope next-state logic. Gate changes take priority over level steps.
  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    cnt_d   = tick ? 16'd0 : cnt_q + 16'd1;
    ramp    = '0;
    case (state_q)
      S_IDLE: begin
        lvl_d = '0;
        if (gate_rise) state_d = S_ATTACK;
      end
      S_ATTACK: begin
        if (!gate) begin
          state_d = S_RELEASE;
        end else if (tick) begin
          ramp  = ramp_up(lvl_q, rate_step(attack));
          lvl_d = ramp[15:0];
          if (ramp[16]) state_d = S_DECAY;
        end
      end
      S_DECAY: begin
        if (!gate) begin
          state_d = S_RELEASE;
        end else if (tick) begin
          ramp  = ramp_down(lvl_q, sus_t, rate_step(decay));
          lvl_d = ramp[15:0];
          if (ramp[16]) state_d = S_SUSTAIN;
        end
      end
      S_SUSTAIN: begin
        if (!gate)     state_d = S_RELEASE;
        else if (tick) lvl_d   = sus_t;
      end
      S_RELEASE: begin
        if (gate_rise) begin
          state_d = S_ATTACK;
        end else if (tick) begin
          ramp  = ramp_down(lvl_q, 16'h0000, rate_step(release_code));
          lvl_d = ramp[15:0];
          if (ramp[16]) state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        lvl_d   = '0;
      end
    endcase
  end

  // Stage p0 -> p1: register the envelope state and the scaled output sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lvl_q       <= '0;
      cnt_q       <= '0;
      gate_prev_q <= 1'b0;
      out_p1      <= 8'd128;
      env_p1      <= '0;
    end else begin
      state_q     <= state_d;
      lvl_q       <= lvl_d;
      cnt_q       <= cnt_d;
      gate_prev_q <= gate;
      out_p1      <= out_p0;
      env_p1      <= env_p0;
    end
  end

  assign signal_out = out_p1;

`ifdef ADSR_ENV_MON_EN
  assign env_out = env_p1;
`else
  logic env_unused;
  assign env_unused = ^env_p1;
`endif

endmodule
